// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: owns the instruction register, sequences
// FETCH/DECODE/EXEC/MEM/WB and arbitrates the single memory port.
module mc_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] instr,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  ext_op,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wd_src,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;

   logic [5:0] opcode_s, funct_s;
   logic is_nop_s, is_rtype_s, is_addu_s, is_subu_s, is_jr_s, is_ori_s, is_lui_s;
   logic is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s, is_illegal_s;
   logic [1:0] exec_ext_op_s;
   logic       exec_src_b_s;
   logic mem_req_s, mem_we_s, pc_we_s, reg_we_s, illegal_s;

   assign opcode_s     = instr_q[31:26];
   assign funct_s      = instr_q[5:0];
   assign is_nop_s     = (instr_q == 32'd0);
   assign is_rtype_s   = (opcode_s == 6'b000000);
   assign is_addu_s    = is_rtype_s && (funct_s == 6'b100001);
   assign is_subu_s    = is_rtype_s && (funct_s == 6'b100011);
   assign is_jr_s      = is_rtype_s && (funct_s == 6'b001000);
   assign is_ori_s     = (opcode_s == 6'b001101);
   assign is_lui_s     = (opcode_s == 6'b001111);
   assign is_lw_s      = (opcode_s == 6'b100011);
   assign is_sw_s      = (opcode_s == 6'b101011);
   assign is_beq_s     = (opcode_s == 6'b000100);
   assign is_j_s       = (opcode_s == 6'b000010);
   assign is_jal_s     = (opcode_s == 6'b000011);
   assign is_illegal_s = !(is_nop_s || is_addu_s || is_subu_s || is_jr_s || is_ori_s ||
                           is_lui_s || is_lw_s || is_sw_s || is_beq_s || is_j_s || is_jal_s);

   // Extender/ALU-B selects chosen in EXEC; re-decoded from instr so they hold through MEM and WB.
   assign exec_ext_op_s = is_ori_s ? 2'd0 : (is_lui_s ? 2'd2 : 2'd1);
   assign exec_src_b_s  = !(is_addu_s || is_subu_s || is_beq_s);

   // Next-state and per-state control decode (pc_we in FETCH is Mealy on mem_ack).
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      pc_we_s   = 1'b0;
      reg_we_s  = 1'b0;
      illegal_s = 1'b0;
      pc_src    = 2'd0;
      ext_op    = 2'd1;
      alu_src_b = 1'b0;
      alu_op    = 2'd0;
      reg_dst   = 2'd0;
      wd_src    = 2'd0;
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         ext_op    = exec_ext_op_s;
         alu_src_b = exec_src_b_s;
      end else begin
         ext_op    = 2'd1;
         alu_src_b = 1'b0;
      end
      case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ack) begin
               instr_d = mem_rdata;
               pc_we_s = 1'b1;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            if (is_j_s) begin
               pc_we_s = 1'b1;
               pc_src  = 2'd2;
            end else if (is_jal_s) begin
               pc_we_s  = 1'b1;
               pc_src   = 2'd2;
               reg_we_s = 1'b1;
               reg_dst  = 2'd2;
               wd_src   = 2'd2;
            end else if (is_jr_s) begin
               pc_we_s = 1'b1;
               pc_src  = 2'd3;
            end else if (is_nop_s) begin
               state_d = S_FETCH;
            end else if (is_illegal_s) begin
               illegal_s = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_subu_s || is_beq_s) begin
               alu_op = 2'd1;
            end else if (is_ori_s || is_lui_s) begin
               alu_op = 2'd2;
            end else begin
               alu_op = 2'd0;
            end
            if (is_beq_s) begin
               pc_we_s = zero;
               pc_src  = 2'd1;
               state_d = S_FETCH;
            end else if (is_lw_s || is_sw_s) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req_s = 1'b1;
            mem_we_s  = is_sw_s;
            if (mem_ack) begin
               state_d = is_lw_s ? S_WB : S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            reg_we_s = 1'b1;
            reg_dst  = (is_addu_s || is_subu_s) ? 2'd1 : 2'd0;
            wd_src   = is_lw_s ? 2'd1 : 2'd0;
            state_d  = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State and instruction register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   // Strobes are forced low while reset is held so nothing escapes before the first edge.
   assign mem_req = mem_req_s & reset_n;
   assign mem_we  = mem_we_s  & reset_n;
   assign pc_we   = pc_we_s   & reset_n;
   assign reg_we  = reg_we_s  & reset_n;
   assign illegal = illegal_s & reset_n;
   assign instr   = instr_q;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: one task per scenario, inline checks.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        zero;
   logic        mem_req, mem_we, pc_we, alu_src_b, reg_we, illegal;
   logic [31:0] instr;
   logic [1:0]  pc_src, ext_op, alu_op, reg_dst, wd_src;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;

   mc_ctrl dut (
      .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .zero(zero),
      .mem_req(mem_req), .mem_we(mem_we), .instr(instr), .pc_we(pc_we), .pc_src(pc_src),
      .ext_op(ext_op), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
      .reg_dst(reg_dst), .wd_src(wd_src), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch of word w; leaves the DUT in DECODE.
   task automatic fetch(input logic [31:0] w);
      mem_rdata = w;
      mem_ack   = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || mem_req !== 1'b1 || mem_we !== 1'b0 || pc_we !== 1'b1 || pc_src !== 2'd0) begin
         errors++;
         $display("FAIL fetch_%h: state=%0d req=%b we=%b pc_we=%b pc_src=%0d, expected 0 1 0 1 0",
                  w, state, mem_req, mem_we, pc_we, pc_src);
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (instr !== w || state !== 3'd1) begin
         errors++;
         $display("FAIL fetch_capture: instr=%h state=%0d, expected %h 1", instr, state, w);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mem_ack = 1'b0; zero = 1'b0; mem_rdata = 32'd0;
      #12;
      checks++;
      if (state !== 3'd0 || instr !== 32'd0 || mem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0 ||
          mem_we !== 1'b0 || ext_op !== 2'd1 || alu_src_b !== 1'b0 || pc_src !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d instr=%h req=%b ext_op=%0d, expected 0 0 0 1",
                  state, instr, mem_req, ext_op);
      end
      tick();
      reset_n = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1 || state !== 3'd0) begin
         errors++;
         $display("FAIL reset_release: req=%b state=%0d, expected 1 0", mem_req, state);
      end
   endtask

   task automatic test_ori();
      fetch(32'h3408_1234);
      checks++;
      if (pc_we !== 1'b0 || ext_op !== 2'd1) begin
         errors++;
         $display("FAIL ori_decode: pc_we=%b ext_op=%0d, expected 0 1", pc_we, ext_op);
      end
      tick();
      checks++;
      if (state !== 3'd2 || ext_op !== 2'd0 || alu_src_b !== 1'b1 || alu_op !== 2'd2 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL ori_exec: state=%0d ext_op=%0d srcb=%b alu_op=%0d pc_we=%b, expected 2 0 1 2 0",
                  state, ext_op, alu_src_b, alu_op, pc_we);
      end
      tick();
      checks++;
      if (state !== 3'd4 || reg_we !== 1'b1 || reg_dst !== 2'd0 || wd_src !== 2'd0 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL ori_wb: state=%0d reg_we=%b reg_dst=%0d wd_src=%0d pc_we=%b, expected 4 1 0 0 0",
                  state, reg_we, reg_dst, wd_src, pc_we);
      end
      tick();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL ori_done: state=%0d, expected 0", state);
      end
   endtask

   task automatic test_lw_wait();
      logic [2:0] exp_st [0:7];
      exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      fetch(32'h8C09_FFFC);
      for (int cyc = 1; cyc < 8; cyc++) begin
         mem_ack = (cyc == 6);
         #1;
         checks++;
         if (state !== exp_st[cyc] || ext_op !== 2'd1 || mem_we !== 1'b0 ||
             mem_req !== (cyc >= 3 && cyc <= 6) || reg_we !== (cyc == 7) ||
             (cyc == 7 && (wd_src !== 2'd1 || reg_dst !== 2'd0))) begin
            errors++;
            $display("FAIL lw_cycle%0d: state=%0d ext_op=%0d req=%b reg_we=%b wd_src=%0d, expected state %0d",
                     cyc, state, ext_op, mem_req, reg_we, wd_src, exp_st[cyc]);
         end
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL lw_latency: state=%0d after 8 cycles, expected 0", state);
      end
   endtask

   task automatic test_reset_abort();
      fetch(32'h8C09_FFFC);
      tick();
      tick();
      #2;
      checks++;
      if (state !== 3'd3 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: state=%0d req=%b, expected 3 1", state, mem_req);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || reg_we !== 1'b0 || state !== 3'd0 || instr !== 32'd0) begin
         errors++;
         $display("FAIL abort_mem: req=%b we=%b reg_we=%b state=%0d, expected 0 0 0 0", mem_req, mem_we, reg_we, state);
      end
      tick();
      reset_n = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: state=%0d req=%b, expected 0 1", state, mem_req);
      end
      // sw reaching MEM, then reset while mem_we is high
      fetch(32'hAC0A_0004);
      tick();
      checks++;
      if (state !== 3'd2 || ext_op !== 2'd1 || alu_src_b !== 1'b1 || alu_op !== 2'd0) begin
         errors++;
         $display("FAIL sw_exec: state=%0d ext_op=%0d srcb=%b alu_op=%0d, expected 2 1 1 0", state, ext_op, alu_src_b, alu_op);
      end
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || state !== 3'd3) begin
         errors++;
         $display("FAIL sw_mem: req=%b we=%b state=%0d, expected 1 1 3", mem_req, mem_we, state);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_sw: we=%b req=%b, expected 0 0", mem_we, mem_req);
      end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_beq();
      for (int k = 0; k < 2; k++) begin
         fetch(32'h1000_0003);
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         zero = (k == 0);
         #1;
         checks++;
         if (state !== 3'd2 || pc_we !== (k == 0) || (k == 0 && pc_src !== 2'd1) || reg_we !== 1'b0 ||
             alu_op !== 2'd1 || alu_src_b !== 1'b0 || ext_op !== 2'd1) begin
            errors++;
            $display("FAIL beq_exec_zero%0d: state=%0d pc_we=%b pc_src=%0d reg_we=%b alu_op=%0d",
                     1 - k, state, pc_we, pc_src, reg_we, alu_op);
         end
         tick();
         zero = 1'b0;
         checks++;
         if (state !== 3'd0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL beq_done%0d: state=%0d reg_we=%b, expected 0 0", k, state, reg_we);
         end
      end
   endtask

   task automatic test_jumps();
      fetch(32'h0C00_0040);
      checks++;
      if (pc_we !== 1'b1 || pc_src !== 2'd2 || reg_we !== 1'b1 || reg_dst !== 2'd2 || wd_src !== 2'd2) begin
         errors++;
         $display("FAIL jal_decode: pc_we=%b pc_src=%0d reg_we=%b reg_dst=%0d wd_src=%0d, expected 1 2 1 2 2",
                  pc_we, pc_src, reg_we, reg_dst, wd_src);
      end
      tick();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL jal_done: state=%0d, expected 0", state);
      end
      fetch(32'h03E0_0008);
      checks++;
      if (pc_we !== 1'b1 || pc_src !== 2'd3 || reg_we !== 1'b0) begin
         errors++;
         $display("FAIL jr_decode: pc_we=%b pc_src=%0d reg_we=%b, expected 1 3 0", pc_we, pc_src, reg_we);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [0:1];
      words = '{32'h0109_5021, 32'h0109_5023};
      for (int k = 0; k < 2; k++) begin
         fetch(words[k]);
         tick();
         checks++;
         if (state !== 3'd2 || alu_src_b !== 1'b0 || alu_op !== k[1:0]) begin
            errors++;
            $display("FAIL rtype%0d_exec: state=%0d srcb=%b alu_op=%0d, expected 2 0 %0d", k, state, alu_src_b, alu_op, k);
         end
         tick();
         checks++;
         if (state !== 3'd4 || reg_we !== 1'b1 || reg_dst !== 2'd1 || wd_src !== 2'd0) begin
            errors++;
            $display("FAIL rtype%0d_wb: state=%0d reg_we=%b reg_dst=%0d, expected 4 1 1", k, state, reg_we, reg_dst);
         end
         tick();
      end
   endtask

   task automatic test_illegal_nop();
      logic [31:0] words [0:1];
      words = '{32'hFC00_0000, 32'h0000_0000};
      for (int k = 0; k < 2; k++) begin
         fetch(words[k]);
         checks++;
         if (illegal !== (k == 0) || reg_we !== 1'b0 || mem_we !== 1'b0 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL decode_%h: illegal=%b reg_we=%b mem_we=%b pc_we=%b, expected %b 0 0 0",
                     words[k], illegal, reg_we, mem_we, pc_we, (k == 0));
         end
         tick();
         checks++;
         if (state !== 3'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL return_%h: state=%0d illegal=%b, expected 0 0", words[k], state, illegal);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ori();
      test_lw_wait();
      test_reset_abort();
      test_beq();
      test_jumps();
      test_back_to_back();
      test_illegal_nop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
